// File: rtl/hadamard_symbol_serializer_if.sv
// Frame-in / symbol-out handshake bundle for the Hadamard symbol serializer.
// slave is the serializer's view; master is the frame source plus symbol sink.
interface hadamard_symbol_serializer_if #(
  parameter int BIT_NUM  = 7,
  parameter int HADAMARD = 16
);
  logic [BIT_NUM*HADAMARD-1:0] in_data;
  logic                        in_valid;
  logic                        in_ready;
  logic [BIT_NUM-1:0]          out_sym;
  logic                        out_valid;
  logic                        out_ready;
  logic                        out_preamble;
  logic                        out_first;
  logic                        out_last;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_sym, out_valid, out_preamble, out_first, out_last
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_sym, out_valid, out_preamble, out_first, out_last
  );
endinterface

// File: rtl/hadamard_symbol_serializer.sv
// Buffers up to two encoded Hadamard frames and streams them one symbol per
// cycle, each frame preceded by a fixed preamble, under sink backpressure.
module hadamard_symbol_serializer #(
  parameter int                 HADAMARD      = 16,
  parameter int                 PAM_LEVEL_LOG = 3,
  parameter int                 BIT_NUM       = 7,
  parameter int                 PREAMBLE_LEN  = 4,
  parameter logic [BIT_NUM-1:0] PREAMBLE_SYM  = 7'h55
) (
  input  logic                          clk,
  input  logic                          reset,
  hadamard_symbol_serializer_if.slave   bus,
  output logic [15:0]                   frame_count
);
  localparam int M       = BIT_NUM * HADAMARD;
  localparam int KW      = $clog2(HADAMARD);
  localparam int CNT_MAX = (PREAMBLE_LEN > HADAMARD) ? PREAMBLE_LEN : HADAMARD;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PRE   = 2'd1;
  localparam logic [1:0] S_PAY   = 2'd2;
  localparam logic [1:0] S_START = (PREAMBLE_LEN > 0) ? S_PRE : S_PAY;

  generate
    if (BIT_NUM != KW + PAM_LEVEL_LOG) begin : g_bad_width
      $error("BIT_NUM must equal log2(HADAMARD)+PAM_LEVEL_LOG");
    end
  endgenerate

  logic [M-1:0]       mem_q [2];
  logic               wr_ptr_q, wr_ptr_d;
  logic               rd_ptr_q, rd_ptr_d;
  logic [1:0]         count_q, count_d;
  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [15:0]        frame_cnt_q, frame_cnt_d;
  logic               push, xfer, pop, at_pre_end, at_last;
  logic [BIT_NUM-1:0] head_sym [HADAMARD];

  generate
    for (genvar gi = 0; gi < HADAMARD; gi++) begin : g_head
      assign head_sym[gi] = mem_q[rd_ptr_q][gi*BIT_NUM +: BIT_NUM];
    end
  endgenerate

  assign bus.in_ready = (count_q != 2'd2) && !reset;
  assign push         = bus.in_valid && bus.in_ready;
  assign xfer         = bus.out_valid && bus.out_ready;
  assign at_last      = (state_q == S_PAY) && (cnt_q == CW'(HADAMARD - 1));
  assign at_pre_end   = (state_q == S_PRE) && (int'(cnt_q) == PREAMBLE_LEN - 1);
  assign pop          = at_last && xfer;

  always_comb begin
    count_d     = count_q + {1'b0, push} - {1'b0, pop};
    wr_ptr_d    = wr_ptr_q ^ push;
    rd_ptr_d    = rd_ptr_q ^ pop;
    frame_cnt_d = frame_cnt_q + {15'd0, pop};
    state_d     = state_q;
    cnt_d       = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (count_q != 2'd0) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_PRE: begin
        if (xfer) begin
          if (at_pre_end) begin
            state_d = S_PAY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_PAY: begin
        if (xfer) begin
          if (at_last) begin
            // A frame pushed on this same edge counts as remaining: no gap cycle.
            cnt_d   = '0;
            state_d = ((count_q > 2'd1) || push) ? S_START : S_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      frame_cnt_q <= 16'd0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.in_data;
    end
  end

  always_comb begin
    bus.out_sym = '0;
    if (state_q == S_PRE) begin
      bus.out_sym = PREAMBLE_SYM;
    end else if (state_q == S_PAY) begin
      bus.out_sym = head_sym[cnt_q[KW-1:0]];
    end
  end

  assign bus.out_valid    = (state_q != S_IDLE);
  assign bus.out_preamble = (state_q == S_PRE);
  assign bus.out_first    = (state_q == S_PAY) && (cnt_q == '0);
  assign bus.out_last     = at_last;
  assign frame_count      = frame_cnt_q;
endmodule
